axis_triplet_gather: RTL and testbench

- Upstream feeder for the three-input float adder.
- Takes one AXI-stream of SIZE-bit IEEE-754 words and groups every three consecutive words into a triplet.
- Presents each triplet on three independent AXI-stream masters (a, b, c) that connect directly to the adder's a/b/c slave ports.
- Word order maps to channel order: first word to a, second to b, third to c. Each output channel completes its handshake independently, because the adder's slave ports may accept in different cycles.

---
 rtl/axis_triplet_gather.sv | 121 ++++++++++++
 tb/tb_axis_triplet_gather.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_triplet_gather.sv
// rtl/axis_triplet_gather.sv - groups a word stream into {a,b,c} triplets for the three-input adder
// Optional TRIPLET_PAD_EN: tlast on slot 0/1 zero-pads the rest of the triplet.
module axis_triplet_gather #(
  parameter int SIZE = 64
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [SIZE-1:0] s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic            s_axis_tlast,
  output logic [SIZE-1:0] m_axis_a_tdata,
  output logic            m_axis_a_tvalid,
  input  logic            m_axis_a_tready,
  output logic [SIZE-1:0] m_axis_b_tdata,
  output logic            m_axis_b_tvalid,
  input  logic            m_axis_b_tready,
  output logic [SIZE-1:0] m_axis_c_tdata,
  output logic            m_axis_c_tvalid,
  input  logic            m_axis_c_tready,
  output logic [31:0]     triplet_count
);

  logic [SIZE-1:0] w0, w1, w2;
  logic [SIZE-1:0] oa, ob, oc;
  logic [1:0]      cnt;
  logic            out_full;
  logic            a_done, b_done, c_done;
  logic            live;
  logic            a_hs, b_hs, c_hs;
  logic            all_drain, xfer, accept;
  logic [1:0]      wr_idx;

  assign m_axis_a_tvalid = out_full && !a_done;
  assign m_axis_b_tvalid = out_full && !b_done;
  assign m_axis_c_tvalid = out_full && !c_done;
  assign m_axis_a_tdata  = oa;
  assign m_axis_b_tdata  = ob;
  assign m_axis_c_tdata  = oc;

  assign a_hs = m_axis_a_tvalid && m_axis_a_tready;
  assign b_hs = m_axis_b_tvalid && m_axis_b_tready;
  assign c_hs = m_axis_c_tvalid && m_axis_c_tready;

  assign all_drain = out_full && (a_done || a_hs) && (b_done || b_hs) && (c_done || c_hs);
  assign xfer      = (cnt == 2'd3) && (!out_full || all_drain);

  // live holds tready low while reset is asserted and for the first edge after release
  assign s_axis_tready = live && ((cnt != 2'd3) || xfer);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign wr_idx        = xfer ? 2'd0 : cnt;

`ifndef TRIPLET_PAD_EN
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt  <= 2'd0;
      w0   <= '0;
      w1   <= '0;
      w2   <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        case (wr_idx)
          2'd0:    w0 <= s_axis_tdata;
          2'd1:    w1 <= s_axis_tdata;
          default: w2 <= s_axis_tdata;
        endcase
        cnt <= wr_idx + 2'd1;
`ifdef TRIPLET_PAD_EN
        if (s_axis_tlast && (wr_idx != 2'd2)) begin
          if (wr_idx == 2'd0) w1 <= '0;
          w2  <= '0;
          cnt <= 2'd3;
        end
`endif
      end else if (xfer) begin
        cnt <= 2'd0;
      end
    end
  end

  // a new triplet may load on the very edge the previous one finishes draining
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      oa            <= '0;
      ob            <= '0;
      oc            <= '0;
      out_full      <= 1'b0;
      a_done        <= 1'b0;
      b_done        <= 1'b0;
      c_done        <= 1'b0;
      triplet_count <= 32'd0;
    end else begin
      if (all_drain) triplet_count <= triplet_count + 32'd1;
      if (xfer) begin
        oa       <= w0;
        ob       <= w1;
        oc       <= w2;
        out_full <= 1'b1;
        a_done   <= 1'b0;
        b_done   <= 1'b0;
        c_done   <= 1'b0;
      end else if (all_drain) begin
        out_full <= 1'b0;
        a_done   <= 1'b0;
        b_done   <= 1'b0;
        c_done   <= 1'b0;
      end else begin
        a_done <= a_done || a_hs;
        b_done <= b_done || b_hs;
        c_done <= c_done || c_hs;
      end
    end
  end

endmodule

// File: tb/tb_axis_triplet_gather.sv
// tb/tb_axis_triplet_gather.sv - randomized and directed bench for axis_triplet_gather
module tb_axis_triplet_gather;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [63:0] a_tdata, b_tdata, c_tdata;
  logic        a_tvalid, b_tvalid, c_tvalid;
  logic        a_rdy, b_rdy, c_rdy;
  logic [31:0] triplet_count;

  axis_triplet_gather #(.SIZE(64)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_a_tdata(a_tdata), .m_axis_a_tvalid(a_tvalid), .m_axis_a_tready(a_rdy),
    .m_axis_b_tdata(b_tdata), .m_axis_b_tvalid(b_tvalid), .m_axis_b_tready(b_rdy),
    .m_axis_c_tdata(c_tdata), .m_axis_c_tvalid(c_tvalid), .m_axis_c_tready(c_rdy),
    .triplet_count(triplet_count)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  logic [63:0] qa[$], qb[$], qc[$];
  int in_idx, na, nb, nc;
  logic acc_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dbl(input int i);
    return $realtobits($itor(i));
  endfunction

  function automatic int min3(input int x, input int y, input int z);
    int m;
    m = (x < y) ? x : y;
    return (m < z) ? m : z;
  endfunction

  // reference: word k of the accepted stream belongs to channel k mod 3
  task automatic push_word(input logic [63:0] d, input logic last);
    case (in_idx % 3)
      0: qa.push_back(d);
      1: qb.push_back(d);
      default: qc.push_back(d);
    endcase
    in_idx++;
`ifdef TRIPLET_PAD_EN
    if (last) begin
      while (in_idx % 3 != 0) begin
        if (in_idx % 3 == 1) qb.push_back(64'd0);
        else qc.push_back(64'd0);
        in_idx++;
      end
    end
`else
    if (last) begin end
`endif
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete(); qc.delete();
    in_idx = 0; na = 0; nb = 0; nc = 0;
  endtask

  task automatic step();
    @(negedge aclk);
    acc_last = s_tvalid && s_tready;
    if (acc_last) push_word(s_tdata, s_tlast);
    if (a_tvalid && a_rdy) begin
      check("a_expected", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) check("a_data", a_tdata, qa.pop_front());
      na++;
    end
    if (b_tvalid && b_rdy) begin
      check("b_expected", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) check("b_data", b_tdata, qb.pop_front());
      nb++;
    end
    if (c_tvalid && c_rdy) begin
      check("c_expected", 64'(qc.size() != 0), 64'd1);
      if (qc.size() != 0) check("c_data", c_tdata, qc.pop_front());
      nc++;
    end
    @(posedge aclk);
    #1;
    check("triplet_count_model", 64'(triplet_count), 64'(min3(na, nb, nc)));
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    int n;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_last && n < 200);
    check("send_accepted", 64'(acc_last), 64'd1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cyc;
    aresetn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    a_rdy = 1'b1; b_rdy = 1'b1; c_rdy = 1'b1;
    model_reset();
    #12;
    check("rst_a_tvalid", 64'(a_tvalid), 64'd0);
    check("rst_c_tvalid", 64'(c_tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_count", 64'(triplet_count), 64'd0);
    check("rst_b_tdata", b_tdata, 64'd0);
    #11 aresetn = 1'b1;
    @(posedge aclk); #1;
    idle(2);

    // streaming 1.0..6.0 with every consumer ready
    send(dbl(1), 0); send(dbl(2), 0); send(dbl(3), 0);
    check("t1_no_early_valid", 64'(a_tvalid), 64'd0);
    check("t1_tready_after3", 64'(s_tready), 64'd1);
    send(dbl(4), 0);
    check("t1_a_valid", 64'(a_tvalid && b_tvalid && c_tvalid), 64'd1);
    check("t1_a_data", a_tdata, dbl(1));
    check("t1_c_data", c_tdata, dbl(3));
    send(dbl(5), 0);
    check("t1_tready5", 64'(s_tready), 64'd1);
    send(dbl(6), 0);
    idle(3);
    check("t1_count", 64'(triplet_count), 64'd2);

    // c stalled: collect stage fills and input back-pressures
    c_rdy = 1'b0;
    for (int i = 1; i <= 6; i++) send(dbl(i), 0);
    check("t2_tready_low", 64'(s_tready), 64'd0);
    check("t2_c_valid", 64'(c_tvalid), 64'd1);
    check("t2_c_data", c_tdata, dbl(3));
    check("t2_ab_drained", 64'(a_tvalid || b_tvalid), 64'd0);
    s_tdata = dbl(7); s_tvalid = 1'b1;
    idle(3);
    check("t2_stall_no_accept", 64'(acc_last), 64'd0);
    c_rdy = 1'b1;
    send(dbl(7), 0); send(dbl(8), 0); send(dbl(9), 0);
    idle(6);
    check("t2_count", 64'(triplet_count), 64'd5);

    // skewed drain: a at k, b at k+2, c at k+5
    a_rdy = 1'b0; b_rdy = 1'b0; c_rdy = 1'b0;
    for (int i = 11; i <= 16; i++) send(dbl(i), 0);
    check("t3_tready_low", 64'(s_tready), 64'd0);
    a_rdy = 1'b1; step(); a_rdy = 1'b0;
    check("t3_a_dropped", 64'({a_tvalid, b_tvalid, c_tvalid}), 64'b011);
    step();
    b_rdy = 1'b1; step(); b_rdy = 1'b0;
    check("t3_b_dropped", 64'({a_tvalid, b_tvalid, c_tvalid}), 64'b001);
    step(); step();
    c_rdy = 1'b1; step(); c_rdy = 1'b0;
    check("t3_no_bubble", 64'({a_tvalid, b_tvalid, c_tvalid}), 64'b111);
    check("t3_next_a", a_tdata, dbl(14));
    check("t3_count", 64'(triplet_count), 64'd6);
    a_rdy = 1'b1; b_rdy = 1'b1; c_rdy = 1'b1;
    idle(4);
    check("t3_count_final", 64'(triplet_count), 64'd7);

`ifdef TRIPLET_PAD_EN
    send(dbl(1), 0); send(dbl(2), 1);
    step();
    check("pad_c_valid", 64'(c_tvalid), 64'd1);
    check("pad_c_zero", c_tdata, 64'd0);
    send(dbl(7), 0); send(dbl(8), 0); send(dbl(9), 0);
    idle(4);
    check("pad_count", 64'(triplet_count), 64'd9);
`endif

    // reset with cnt=2 and output stage holding a stalled triplet
    c_rdy = 1'b0;
    for (int i = 301; i <= 305; i++) send(dbl(i), 0);
    check("t4_pre_c_valid", 64'(c_tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    check("t4_valids_zero", 64'({a_tvalid, b_tvalid, c_tvalid}), 64'd0);
    check("t4_count_zero", 64'(triplet_count), 64'd0);
    check("t4_tready_zero", 64'(s_tready), 64'd0);
    model_reset();
    c_rdy = 1'b1;
    idle(2);
    aresetn = 1'b1;
    idle(2);
    send(dbl(401), 0); send(dbl(402), 0); send(dbl(403), 0);
    idle(4);
    check("t4_post_count", 64'(triplet_count), 64'd1);

    // random traffic on all four streams
    cyc = 0;
    acc_last = 1'b0;
    while ((in_idx < 10000 || in_idx % 3 != 0) && cyc < 60000) begin
      if (!s_tvalid || acc_last) begin
        s_tvalid = ($urandom % 10) < 7;
        s_tdata = {$urandom, $urandom};
`ifdef TRIPLET_PAD_EN
        s_tlast = ($urandom % 8) == 0;
`else
        s_tlast = $urandom % 2;
`endif
      end
      a_rdy = ($urandom % 10) < 6;
      b_rdy = ($urandom % 10) < 6;
      c_rdy = ($urandom % 10) < 6;
      step();
      cyc++;
    end
    check("rand_budget", 64'(cyc < 60000), 64'd1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    a_rdy = 1'b1; b_rdy = 1'b1; c_rdy = 1'b1;
    idle(8);
    check("rand_count", 64'(triplet_count), 64'(in_idx / 3));
    check("rand_q_empty", 64'(qa.size() + qb.size() + qc.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
